// File: rtl/addr_decode_ctrl.sv
// Registered address decoder / slave-select controller for the peripheral bus.
// Decodes the top SEL_BITS of a requested address into a one-hot slave select.
// The select is held until that slave reports ready. Unmapped slots raise
// dec_err, and stalled transactions are aborted with timeout_err.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | no transaction; S_sel low; req/input_addr are decoded
// ST_ACTIVE | slave selected; waiting for its ready or for the timeout
// ST_ERR    | single dec_err cycle; a req here is decoded as in ST_IDLE
module addr_decode_ctrl #(
  parameter int ADDR_W     = 8,
  parameter int SEL_BITS   = 3,
  parameter int NUM_SLAVES = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic [ADDR_W-1:0]     input_addr,
  input  logic [NUM_SLAVES-1:0] s_ready,
  output logic [NUM_SLAVES-1:0] S_sel,
  output logic                  busy,
  output logic                  done,
  output logic                  dec_err,
  output logic                  timeout_err,
  output logic [ADDR_W-1:0]     err_addr
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_ERR    = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [NUM_SLAVES-1:0] sel_d;
  logic                  busy_d, done_d, dec_err_d, timeout_err_d;
  logic [ADDR_W-1:0]     err_addr_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [SEL_BITS-1:0]   idx;
  logic                  idx_mapped;
  logic [NUM_SLAVES-1:0] idx_onehot;
  logic                  sel_ready;
  logic                  cnt_expired;

  assign idx         = input_addr[ADDR_W-1 -: SEL_BITS];
  assign idx_mapped  = ({1'b0, idx} < (SEL_BITS + 1)'(NUM_SLAVES));
  assign idx_onehot  = NUM_SLAVES'(1) << idx;
  // S_sel itself holds the latched slave index as a one-hot mask.
  assign sel_ready   = |(s_ready & S_sel);
  assign cnt_expired = (TIMEOUT > 0) && (cnt_q == CNT_LAST);

  // Next-state and next-output decode; outputs are registered below.
  always_comb begin
    state_d       = state_q;
    sel_d         = S_sel;
    done_d        = 1'b0;
    dec_err_d     = 1'b0;
    timeout_err_d = 1'b0;
    err_addr_d    = err_addr;
    addr_d        = addr_q;
    cnt_d         = cnt_q;

    case (state_q)
      // ERR always leaves after one cycle; a req in that cycle is taken so
      // back-to-back requests behave the same after any pulse.
      ST_IDLE, ST_ERR: begin
        state_d = ST_IDLE;
        sel_d   = '0;
        if (req) begin
          if (idx_mapped) begin
            state_d = ST_ACTIVE;
            sel_d   = idx_onehot;
            addr_d  = input_addr;
            cnt_d   = '0;
          end else begin
            state_d    = ST_ERR;
            dec_err_d  = 1'b1;
            err_addr_d = input_addr;
          end
        end
      end
      ST_ACTIVE: begin
        // Ready takes priority over an expiring timeout on the same edge.
        if (sel_ready) begin
          state_d = ST_IDLE;
          sel_d   = '0;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else if (cnt_expired) begin
          state_d       = ST_IDLE;
          sel_d         = '0;
          timeout_err_d = 1'b1;
          err_addr_d    = addr_q;
          cnt_d         = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = '0;
      end
    endcase

    busy_d = (state_d == ST_ACTIVE) || (state_d == ST_ERR);
  end

  // State, counter and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      S_sel       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      dec_err     <= 1'b0;
      timeout_err <= 1'b0;
      err_addr    <= '0;
      addr_q      <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      S_sel       <= sel_d;
      busy        <= busy_d;
      done        <= done_d;
      dec_err     <= dec_err_d;
      timeout_err <= timeout_err_d;
      err_addr    <= err_addr_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule
